// File: rtl/fetch_if.sv
// fetch_if: control, instruction-memory and downstream word handshake bundle for fetch_unit
interface fetch_if #(parameter int PC_W = 16);
  logic run;
  logic load_en;
  logic [PC_W-1:0] load_addr;
  logic mem_req;
  logic [PC_W-1:0] mem_addr;
  logic mem_ack;
  logic [31:0] mem_data;
  logic [31:0] word_out;
  logic word_valid;
  logic word_ready;
  logic [PC_W-1:0] pc_out;
  modport master (
    input run, load_en, load_addr, mem_ack, mem_data, word_ready,
    output mem_req, mem_addr, word_out, word_valid, pc_out
  );
  modport slave (
    output run, load_en, load_addr, mem_ack, mem_data, word_ready,
    input mem_req, mem_addr, word_out, word_valid, pc_out
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: PC-driven instruction fetch with req/ack memory side and valid/ready word output
module fetch_unit #(
  parameter int PC_W = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int PC_STEP = 1
) (
  input logic clk,
  input logic rst,
  fetch_if.master bus
);
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
  state_t state, next_state;
  logic [PC_W-1:0] pc;
  logic [31:0] word;
  logic take;
  // next state: a jump always returns to IDLE so the old request/word is dropped
  always_comb begin
    take = (state == FETCH) && bus.mem_ack && !bus.load_en;
    next_state = bus.load_en ? IDLE :
                 (state == IDLE && bus.run) ? FETCH :
                 (state == FETCH && bus.mem_ack) ? HOLD :
                 (state == HOLD && bus.word_ready) ? (bus.run ? FETCH : IDLE) :
                 state;
  end
  // state, program counter and captured word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      word <= '0;
    end else begin
      state <= next_state;
      pc <= bus.load_en ? bus.load_addr : take ? pc + PC_W'(PC_STEP) : pc;
      if (take) word <= bus.mem_data;
    end
  end
  assign bus.mem_req = state == FETCH;
  assign bus.mem_addr = pc;
  assign bus.word_valid = state == HOLD;
  assign bus.word_out = word;
  assign bus.pc_out = pc;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized checks of fetch_unit against a transaction-level model
module tb_fetch_unit;
  logic clk = 0;
  logic rst = 1;
  int n_cmp = 0;
  int n_err = 0;
  logic m_req, m_valid;
  logic [15:0] m_pc;
  logic [31:0] m_word;
  fetch_if #(.PC_W(16)) bus();
  fetch_unit #(.PC_W(16), .RESET_PC(16'h0000), .PC_STEP(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [31:0] memval(input logic [15:0] a);
    return a == 16'h0000 ? 32'hF00F1010 : a == 16'h0001 ? 32'h12345678 : {~a, a} ^ 32'h5A5A_0F0F;
  endfunction
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_all(input string tag);
    check({tag, ".req"}, 32'(bus.mem_req), 32'(m_req));
    check({tag, ".valid"}, 32'(bus.word_valid), 32'(m_valid));
    check({tag, ".pc"}, 32'(bus.pc_out), 32'(m_pc));
    if (m_req) check({tag, ".addr"}, 32'(bus.mem_addr), 32'(m_pc));
    if (m_valid) check({tag, ".word"}, bus.word_out, m_word);
  endtask
  task automatic reset_model();
    m_req = 0;
    m_valid = 0;
    m_pc = 16'h0000;
    m_word = 32'h0;
  endtask
  task automatic step(input string tag, input logic r, input logic le, input logic [15:0] la, input logic ak, input logic rd);
    bus.run = r;
    bus.load_en = le;
    bus.load_addr = la;
    bus.mem_ack = ak;
    bus.word_ready = rd;
    bus.mem_data = memval(m_pc);
    if (le) begin
      m_pc = la;
      m_req = 0;
      m_valid = 0;
    end else if (m_req) begin
      if (ak) begin
        m_word = memval(m_pc);
        m_pc = m_pc + 16'd1;
        m_req = 0;
        m_valid = 1;
      end
    end else if (m_valid) begin
      if (rd) begin
        m_valid = 0;
        m_req = r;
      end
    end else m_req = r;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask
  initial begin
    bus.run = 0;
    bus.load_en = 0;
    bus.load_addr = '0;
    bus.mem_ack = 0;
    bus.mem_data = '0;
    bus.word_ready = 0;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check_all("reset");
    check("reset.addr", 32'(bus.mem_addr), 32'h0);
    check("reset.word", bus.word_out, 32'h0);
    step("zw_fetch0", 1, 0, 0, 0, 1);
    step("zw_ack0", 1, 0, 0, 1, 1);
    check("zw_word0", bus.word_out, 32'hF00F1010);
    step("zw_fetch1", 1, 0, 0, 0, 1);
    step("zw_ack1", 1, 0, 0, 1, 1);
    check("zw_word1", bus.word_out, 32'h12345678);
    step("zw_fetch2", 1, 0, 0, 0, 1);
    check("zw_addr2", 32'(bus.mem_addr), 32'h0002);
    repeat (3) step("wait_nack", 1, 0, 0, 0, 0);
    step("wait_ack", 1, 0, 0, 1, 0);
    repeat (5) step("hold", 1, 0, 0, 0, 0);
    step("release", 1, 0, 0, 0, 1);
    step("load_ack", 1, 1, 16'h0100, 1, 1);
    check("load_pc", 32'(bus.pc_out), 32'h0100);
    step("load_resume", 1, 0, 0, 0, 1);
    check("load_addr", 32'(bus.mem_addr), 32'h0100);
    step("jump_ffff", 1, 1, 16'hFFFF, 0, 0);
    step("wrap_fetch", 1, 0, 0, 0, 0);
    step("wrap_ack_stop", 0, 0, 0, 1, 0);
    check("wrap_pc", 32'(bus.pc_out), 32'h0000);
    step("stop_release", 0, 0, 0, 0, 1);
    step("stop_idle", 0, 0, 0, 1, 1);
    step("rst_fetch", 1, 0, 0, 0, 0);
    step("rst_hold", 1, 0, 0, 1, 0);
    #2;
    rst = 1;
    #1;
    reset_model();
    check_all("async_rst");
    check("async_rst.word", bus.word_out, 32'h0);
    @(posedge clk);
    #2;
    rst = 0;
    step("post_rst", 0, 0, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      logic [15:0] la;
      la = ($urandom % 4 == 0) ? 16'hFFFE + 16'($urandom % 2) : 16'($urandom);
      step("rand", $urandom % 4 != 0, $urandom % 20 == 0, la, 1'($urandom), $urandom % 3 != 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
